// File: rtl/iq_nwide_pkg.sv
// Shared types and helpers for the N-lane instruction queue.
package iq_nwide_pkg;

    // Widest lane configuration supported; lane counts are sized for it.
    localparam int unsigned LANE_MAX = 4;

    // Holds 0..LANE_MAX inclusive.
    typedef logic [2:0] lane_cnt_t;

    // Number of contiguous set bits starting at bit 0, looking at the low `lanes` bits only.
    function automatic lane_cnt_t lead_ones(input logic [LANE_MAX-1:0] vec,
                                            input int unsigned lanes);
        lane_cnt_t cnt;
        logic      run;
        cnt = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < LANE_MAX; i++) begin
            if (run && (i < lanes) && vec[i]) begin
                cnt = cnt + lane_cnt_t'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

    function automatic lane_cnt_t sat_min(input lane_cnt_t a, input lane_cnt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/iq_nwide_if.sv
// Fetch/backend bundle for the N-lane instruction queue.
interface iq_nwide_if
    import iq_nwide_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LANES  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_ready;
    logic                    flush;
    logic                    stall;
    lane_cnt_t               width_lim;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    full;

    // Fetch/backend side driving the queue.
    modport master (
        output in_valid, in_data, flush, stall, width_lim,
        input  in_ready, out_valid, out_data, count, empty, full
    );

    // The queue itself.
    modport slave (
        input  in_valid, in_data, flush, stall, width_lim,
        output in_ready, out_valid, out_data, count, empty, full
    );

endinterface

// File: rtl/iq_nwide_prefix_count.sv
// Counts leading contiguous valid lanes starting at lane 0.
module iq_nwide_prefix_count
    import iq_nwide_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0] i_vec,
    output lane_cnt_t        o_cnt
);

    logic [LANE_MAX-1:0] w_vec;

    // Zero-extend to the widest lane configuration.
    always_comb begin
        w_vec             = '0;
        w_vec[LANES-1:0]  = i_vec;
    end

    assign o_cnt = lead_ones(w_vec, LANES);

endmodule

// File: rtl/iq_nwide.sv
// N-lane instruction queue: multi-lane enqueue, width-limited registered dequeue,
// flush, stall and occupancy reporting.
module iq_nwide
    import iq_nwide_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LANES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    iq_nwide_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((LANES < 1) || (LANES > LANE_MAX)) begin : gen_bad_lanes
        $error("iq_nwide: LANES must be in 1..4");
    end
    if ((DEPTH < 2 * LANES) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
        $error("iq_nwide: DEPTH must be a power of two and at least 2*LANES");
    end

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]        r_head, r_tail;
    logic [CNT_W-1:0]        r_count;
    logic [LANES-1:0]        r_out_valid;
    logic [LANES*DATA_W-1:0] r_out_data;

    logic [PTR_W-1:0]        w_head_d, w_tail_d;
    logic [CNT_W-1:0]        w_count_d;
    logic [LANES-1:0]        w_out_valid_d;
    logic [LANES*DATA_W-1:0] w_out_data_d;
    lane_cnt_t               w_n_valid, w_n_enq, w_n_deq, w_wl_sat;
    logic                    w_in_ready;

    // Registered count only: a same-cycle dequeue does not free room for the enqueue.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - LANES));

    iq_nwide_prefix_count #(
        .LANES (LANES)
    ) u_prefix (
        .i_vec (bus.in_valid),
        .o_cnt (w_n_valid)
    );

    // Lane counts for this cycle; dequeue sees only the pre-enqueue occupancy.
    always_comb begin
        w_wl_sat = sat_min(bus.width_lim, lane_cnt_t'(LANES));
        w_n_enq  = '0;
        w_n_deq  = '0;
        if (w_in_ready && !bus.flush) begin
            w_n_enq = w_n_valid;
        end
        if (!bus.stall && !bus.flush) begin
            w_n_deq = (r_count < CNT_W'(w_wl_sat)) ? lane_cnt_t'(r_count) : w_wl_sat;
        end
    end

    // Pointer and occupancy next state; flush empties the queue.
    always_comb begin
        w_head_d  = r_head + PTR_W'(w_n_deq);
        w_tail_d  = r_tail + PTR_W'(w_n_enq);
        w_count_d = r_count + CNT_W'(w_n_enq) - CNT_W'(w_n_deq);
        if (bus.flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end
    end

    // Output register next state; lanes not loaded keep their old data.
    always_comb begin
        w_out_valid_d = r_out_valid;
        w_out_data_d  = r_out_data;
        if (bus.flush) begin
            w_out_valid_d = '0;
        end else if (!bus.stall) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_cnt_t'(i) < w_n_deq) begin
                    w_out_valid_d[i]                  = 1'b1;
                    w_out_data_d[i*DATA_W +: DATA_W]  = r_mem[r_head + PTR_W'(i)];
                end else begin
                    w_out_valid_d[i] = 1'b0;
                end
            end
        end
    end

    // Storage write: accepted lanes go to consecutive slots from tail.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_cnt_t'(i) < w_n_enq) begin
                    r_mem[r_tail + PTR_W'(i)] <= bus.in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Pointer, count and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            r_head      <= w_head_d;
            r_tail      <= w_tail_d;
            r_count     <= w_count_d;
            r_out_valid <= w_out_valid_d;
            r_out_data  <= w_out_data_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.full      = !w_in_ready;
    assign bus.empty     = (r_count == '0);
    assign bus.count     = r_count;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_iq_nwide.sv
// Self-checking bench for iq_nwide (DATA_W=32, DEPTH=16, LANES=2).
module tb_iq_nwide;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int LANES  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iq_nwide_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) bus ();

    iq_nwide #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: accepted entries in FIFO order, popped when they appear on the outputs.
    logic [31:0] sb_q [$];
    int          m_count = 0;
    int          m_tail  = 0;
    logic [1:0]  m_vld   = 2'b00;
    logic        m_new   = 1'b0;
    logic [31:0] m_hold [2];
    bit          mon_en  = 1'b0;
    logic [31:0] mon_exp;

    // One clock: drive inputs, advance the reference model at the edge, return at negedge.
    task automatic cycle(input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                         input logic fl, input logic st, input logic [2:0] wl);
        int n_enq;
        int n_deq;
        int wl_s;
        bit rdy;
        bus.in_valid  = vld;
        bus.in_data   = {d1, d0};
        bus.flush     = fl;
        bus.stall     = st;
        bus.width_lim = wl;
        @(posedge clk);
        rdy   = (DEPTH - m_count) >= LANES;
        n_enq = vld[0] ? (vld[1] ? 2 : 1) : 0;
        if (rst) begin
            sb_q.delete();
            m_count = 0; m_tail = 0; m_vld = 2'b00; m_new = 1'b0;
            m_hold[0] = '0; m_hold[1] = '0;
        end else if (fl) begin
            sb_q.delete();
            m_count = 0; m_tail = 0; m_vld = 2'b00; m_new = 1'b0;
        end else begin
            if (!rdy) n_enq = 0;
            wl_s  = (int'(wl) > LANES) ? LANES : int'(wl);
            n_deq = st ? 0 : ((m_count < wl_s) ? m_count : wl_s);
            if (n_enq > 0) sb_q.push_back(d0);
            if (n_enq > 1) sb_q.push_back(d1);
            m_count = m_count + n_enq - n_deq;
            m_tail  = (m_tail + n_enq) % DEPTH;
            if (!st) begin
                m_new = 1'b1;
                m_vld = (n_deq == 2) ? 2'b11 : ((n_deq == 1) ? 2'b01 : 2'b00);
            end else begin
                m_new = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Per-cycle output monitor: valid mask, count, and data order against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            n_total++;
            if (bus.out_valid !== m_vld)
                $display("FAIL mon_out_valid: got %b want %b at %0t", bus.out_valid, m_vld, $time);
            else n_pass++;
            n_total++;
            if (bus.count !== m_count[4:0])
                $display("FAIL mon_count: got %0d want %0d at %0t", bus.count, m_count, $time);
            else n_pass++;
            for (int i = 0; i < 2; i++) begin
                if (m_vld[i]) begin
                    if (m_new) begin
                        if (sb_q.size() == 0) begin
                            mon_exp = 'x;
                        end else begin
                            mon_exp = sb_q.pop_front();
                        end
                        m_hold[i] = mon_exp;
                    end else begin
                        mon_exp = m_hold[i];
                    end
                    n_total++;
                    if (bus.out_data[i*32 +: 32] !== mon_exp)
                        $display("FAIL mon_out_data lane%0d: got %h want %h at %0t", i,
                                 bus.out_data[i*32 +: 32], mon_exp, $time);
                    else n_pass++;
                end
            end
            if (m_new) m_new = 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        cycle(2'b11, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 3'd2);
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        rst = 1'b0;
        n_total++;
        if ({bus.count, bus.empty, bus.full, bus.in_ready, bus.out_valid} !== {5'd0, 3'b101, 2'b00})
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b r=%b v=%b want 0 1 0 1 00",
                     bus.count, bus.empty, bus.full, bus.in_ready, bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        cycle(2'b11, 32'hA0A0_0001, 32'hB0B0_0002, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd2) $display("FAIL basic_count_c1: got %0d want 2", bus.count);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        n_total++;
        if (bus.out_valid !== 2'b11 || bus.out_data !== {32'hB0B0_0002, 32'hA0A0_0001})
            $display("FAIL basic_out_c2: got v=%b d=%h want v=11 d=b0b00002a0a00001",
                     bus.out_valid, bus.out_data);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        n_total++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.out_valid !== 2'b00)
            $display("FAIL basic_c3: got cnt=%0d e=%b v=%b want 0 1 00",
                     bus.count, bus.empty, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_partial_valid();
        cycle(2'b10, 32'hC0C0_0003, 32'hD0D0_0004, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd0) $display("FAIL lane1_only_count: got %0d want 0", bus.count);
        else n_pass++;
        cycle(2'b01, 32'hE0E0_0005, 32'hF0F0_0006, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd1) $display("FAIL lane0_only_count: got %0d want 1", bus.count);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd7);
        n_total++;
        if (bus.out_valid !== 2'b01) $display("FAIL partial_out_valid: got %b want 01", bus.out_valid);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_full();
        for (int k = 0; k < 7; k++)
            cycle(2'b11, 32'h5500_0000 + 32'(2*k), 32'h5500_0001 + 32'(2*k), 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL full_ready_at14: got %b want 1", bus.in_ready);
        else n_pass++;
        cycle(2'b01, 32'h5500_000E, 32'h0, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd15 || bus.in_ready !== 1'b0 || bus.full !== 1'b1)
            $display("FAIL full_at15: got cnt=%0d r=%b f=%b want 15 0 1",
                     bus.count, bus.in_ready, bus.full);
        else n_pass++;
        cycle(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd15 || bus.full !== 1'b1)
            $display("FAIL full_offer_ignored: got cnt=%0d f=%b want 15 1", bus.count, bus.full);
        else n_pass++;
        // Over-range width_lim saturates to two lanes.
        for (int k = 0; k < 9; k++) cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd3);
        n_total++;
        if (bus.empty !== 1'b1) $display("FAIL full_drained: got empty=%b want 1", bus.empty);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < DEPTH && m_tail != 15; k++)
            cycle(2'b01, 32'h7700_0000 + 32'(k), 32'h0, 1'b0, 1'b0, 3'd2);
        for (int k = 0; k < 4 && m_count != 0; k++) cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        cycle(2'b11, 32'h0000_00AA, 32'h0000_00BB, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (dut.r_mem[15] !== 32'h0000_00AA || dut.r_mem[0] !== 32'h0000_00BB)
            $display("FAIL wrap_slots: got s15=%h s0=%h want 000000aa 000000bb",
                     dut.r_mem[15], dut.r_mem[0]);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        n_total++;
        if (bus.out_valid !== 2'b11 || bus.out_data !== {32'h0000_00BB, 32'h0000_00AA})
            $display("FAIL wrap_order: got v=%b d=%h want 11 000000bb000000aa",
                     bus.out_valid, bus.out_data);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++)
            cycle(2'b11, 32'h5A00_0000 + 32'(2*k), 32'h5A00_0001 + 32'(2*k), 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd6) $display("FAIL stall_pre_count: got %0d want 6", bus.count);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        for (int k = 0; k < 3; k++) begin
            cycle(2'b11, 32'h5B00_0000 + 32'(2*k), 32'h5B00_0001 + 32'(2*k), 1'b0, 1'b1, 3'd2);
            n_total++;
            if (bus.out_valid !== 2'b11 || bus.out_data !== {32'h5A00_0001, 32'h5A00_0000} ||
                bus.count !== 5'(6 + 2*k))
                $display("FAIL stall_hold%0d: got v=%b d=%h cnt=%0d want 11 5a0000015a000000 %0d",
                         k, bus.out_valid, bus.out_data, bus.count, 6 + 2*k);
            else n_pass++;
        end
        for (int k = 0; k < 8 && m_count != 0; k++) cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++)
            cycle(2'b11, 32'h6600_0000 + 32'(2*k), 32'h6600_0001 + 32'(2*k), 1'b0, 1'b0, 3'd0);
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        n_total++;
        if (bus.count !== 5'd8) $display("FAIL flush_pre_count: got %0d want 8", bus.count);
        else n_pass++;
        cycle(2'b11, 32'h6700_0000, 32'h6700_0001, 1'b1, 1'b1, 3'd2);
        n_total++;
        if (bus.count !== 5'd0 || bus.out_valid !== 2'b00 || bus.empty !== 1'b1)
            $display("FAIL flush_clear: got cnt=%0d v=%b e=%b want 0 00 1",
                     bus.count, bus.out_valid, bus.empty);
        else n_pass++;
        cycle(2'b11, 32'h6800_0000, 32'h6800_0001, 1'b0, 1'b0, 3'd0);
        n_total++;
        if (bus.count !== 5'd2) $display("FAIL flush_reenq: got %0d want 2", bus.count);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd2);
        n_total++;
        if (bus.out_data !== {32'h6800_0001, 32'h6800_0000})
            $display("FAIL flush_after_data: got %h want 6800000168000000", bus.out_data);
        else n_pass++;
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_reset_mid();
        cycle(2'b11, 32'h9900_0000, 32'h9900_0001, 1'b0, 1'b0, 3'd0);
        cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1);
        rst = 1'b1;
        cycle(2'b11, 32'h9A00_0000, 32'h9A00_0001, 1'b1, 1'b1, 3'd2);
        rst = 1'b0;
        n_total++;
        if (bus.count !== 5'd0 || bus.out_data !== 64'h0 || bus.empty !== 1'b1)
            $display("FAIL reset_mid: got cnt=%0d d=%h e=%b want 0 0 1",
                     bus.count, bus.out_data, bus.empty);
        else n_pass++;
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.stall     = 1'b0;
        bus.width_lim = '0;
        m_hold[0]     = '0;
        m_hold[1]     = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial_valid();
        test_full();
        test_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
